// File: rtl/axil_req_sequencer.sv
// Request FIFO in front of an AXI4-Lite master port: queued write/read requests are
// replayed one at a time, in order, and each completion returns a single response pulse.
module axil_req_sequencer #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    rsp_valid,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [7:0]              err_count
);
   // state  | meaning
   // IDLE   | waiting for a queued request; pops the head into the command register
   // WR_REQ | AW and W offered; each valid drops on its own handshake
   // WR_B   | bready high, waiting for the write response
   // RD_AR  | AR offered
   // RD_R   | rready high, waiting for read data
   // RSP    | one cycle; the response pulse follows on the next cycle

   localparam int PW = $clog2(DEPTH);
   localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_B, RD_AR, RD_R, RSP} state_t;

   state_t                 state, state_nx;
   logic [EW-1:0]          mem [DEPTH];
   logic [EW-1:0]          head;
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [PW:0]            count, count_nx;
   logic                   push, pop;
   logic [ADDR_WIDTH-1:0]  cmd_addr;
   logic [DATA_WIDTH-1:0]  cmd_data;
   logic                   awvalid_nx, wvalid_nx, arvalid_nx, bready_nx, rready_nx;
   logic                   rsp_load, rsp_write_nx, rsp_err_nx;
   logic [DATA_WIDTH-1:0]  rsp_data_nx;

   assign head       = mem[rd_ptr];
   assign push       = req_valid && req_ready;
   assign pop        = (state == IDLE) && (count != '0);
   assign fifo_count = count;
   assign awaddr     = cmd_addr;
   assign araddr     = cmd_addr;
   assign wdata      = cmd_data;

   always_comb begin
      count_nx = count;
      case ({push, pop})
         2'b10:   count_nx = count + (PW+1)'(1);
         2'b01:   count_nx = count - (PW+1)'(1);
         default: count_nx = count;
      endcase
   end

   // req_ready tracks the next count, so it never depends combinationally on an input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count     <= count_nx;
         req_ready <= (count_nx != FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {req_write, req_addr, req_wdata};
   end

   always_comb begin
      state_nx     = state;
      awvalid_nx   = 1'b0;
      wvalid_nx    = 1'b0;
      arvalid_nx   = 1'b0;
      bready_nx    = 1'b0;
      rready_nx    = 1'b0;
      rsp_load     = 1'b0;
      rsp_write_nx = 1'b0;
      rsp_err_nx   = 1'b0;
      rsp_data_nx  = '0;
      case (state)
         IDLE: begin
            if (pop) begin
               if (head[EW-1]) begin
                  state_nx   = WR_REQ;
                  awvalid_nx = 1'b1;
                  wvalid_nx  = 1'b1;
               end else begin
                  state_nx   = RD_AR;
                  arvalid_nx = 1'b1;
               end
            end
         end
         WR_REQ: begin
            awvalid_nx = awvalid && !awready;
            wvalid_nx  = wvalid && !wready;
            if (!awvalid_nx && !wvalid_nx) begin
               state_nx  = WR_B;
               bready_nx = 1'b1;
            end
         end
         WR_B: begin
            if (bvalid) begin
               state_nx     = RSP;
               rsp_load     = 1'b1;
               rsp_write_nx = 1'b1;
               rsp_err_nx   = (bresp != 2'b00);
            end else begin
               bready_nx = 1'b1;
            end
         end
         RD_AR: begin
            if (arready) begin
               state_nx  = RD_R;
               rready_nx = 1'b1;
            end else begin
               arvalid_nx = 1'b1;
            end
         end
         RD_R: begin
            if (rvalid) begin
               state_nx    = RSP;
               rsp_load    = 1'b1;
               rsp_data_nx = rdata;
               rsp_err_nx  = (rresp != 2'b00);
            end else begin
               rready_nx = 1'b1;
            end
         end
         RSP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         arvalid   <= 1'b0;
         bready    <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         err_count <= '0;
         cmd_addr  <= '0;
         cmd_data  <= '0;
      end else begin
         awvalid   <= awvalid_nx;
         wvalid    <= wvalid_nx;
         arvalid   <= arvalid_nx;
         bready    <= bready_nx;
         rready    <= rready_nx;
         rsp_valid <= (state == RSP);
         busy      <= (state_nx != IDLE) || (count_nx != '0);
         if (pop) begin
            cmd_addr <= head[EW-2 -: ADDR_WIDTH];
            cmd_data <= head[DATA_WIDTH-1:0];
         end
         // captured on the response handshake and held until the next one
         if (rsp_load) begin
            rsp_write <= rsp_write_nx;
            rsp_data  <= rsp_data_nx;
            rsp_err   <= rsp_err_nx;
         end
         if (state == RSP && rsp_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_axil_req_sequencer.sv
// Randomized bench: request stream and AXI slave driven on negedge, responses scored
// against an in-order transaction model with its own shadow memory.
module tb_axil_req_sequencer;
   localparam int AW = 2;
   localparam int DW = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr, awaddr, araddr;
   logic [DW-1:0] req_wdata, wdata, rdata, rsp_data;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;
   logic rsp_valid, rsp_write, rsp_err, busy;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   axil_req_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .fifo_count(fifo_count), .err_count(err_count)
   );

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            acc_cyc;
   } req_t;

   req_t stim_q[$];
   req_t exp_q[$];
   logic err_q[$];
   logic [DW-1:0] ref_mem [4];
   logic [DW-1:0] slave_mem [4];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int rsp_seen = 0;
   int wr_lat = -1;
   int exp_errs = 0;
   int aw_pct, w_pct, ar_pct, b_pct, r_pct, req_pct, err_pct;
   logic [1:0] bresp_err = 2'b10;
   logic [1:0] rresp_err = 2'b11;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_done, w_done, ar_done;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic [DW-1:0] s_wdata;
   logic prev_awv, prev_wv, prev_arv;
   logic [AW-1:0] prev_awaddr, prev_araddr;
   logic [DW-1:0] prev_wdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_pct(input int p);
      aw_pct = p; w_pct = p; ar_pct = p; b_pct = p; r_pct = p; req_pct = p;
   endtask

   task automatic add_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      req_t r;
      r.wr = wr; r.addr = addr; r.data = data; r.acc_cyc = 0;
      stim_q.push_back(r);
   endtask

   task automatic flush_tb();
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      stim_q.delete(); exp_q.delete(); err_q.delete();
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0;
      prev_awv = 0; prev_wv = 0; prev_arv = 0;
      prev_awaddr = '0; prev_araddr = '0; prev_wdata = '0;
      for (int i = 0; i < 4; i++) begin ref_mem[i] = '0; slave_mem[i] = '0; end
      exp_errs = 0;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
         check_val("rsp_expected", 32'(exp_q.size() != 0), 1);
         check_val("rsp_slave_resp", 32'(err_q.size() != 0), 1);
         if (exp_q.size() != 0 && err_q.size() != 0) begin
            req_t r;
            logic e;
            r = exp_q.pop_front();
            e = err_q.pop_front();
            check_val("rsp_write", 32'(rsp_write), 32'(r.wr));
            check_val("rsp_data", 32'(rsp_data), r.wr ? 32'd0 : 32'(ref_mem[r.addr]));
            check_val("rsp_err", 32'(rsp_err), 32'(e));
            if (r.wr) begin
               ref_mem[r.addr] = r.data;
               wr_lat = cyc - r.acc_cyc - 1;
            end
            if (e && exp_errs < 255) exp_errs++;
            rsp_seen++;
         end
      end
      // a valid that was not accepted on the last edge must still be up with the same payload
      if (prev_awv && !aw_hs) begin
         check_val("awvalid_hold", 32'(awvalid), 1);
         check_val("awaddr_hold", 32'(awaddr), 32'(prev_awaddr));
      end
      if (prev_wv && !w_hs) begin
         check_val("wvalid_hold", 32'(wvalid), 1);
         check_val("wdata_hold", 32'(wdata), 32'(prev_wdata));
      end
      if (prev_arv && !ar_hs) begin
         check_val("arvalid_hold", 32'(arvalid), 1);
         check_val("araddr_hold", 32'(araddr), 32'(prev_araddr));
      end
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (b_hs) begin bvalid = 0; aw_done = 0; w_done = 0; end
      if (ar_hs) ar_done = 1;
      if (r_hs) begin rvalid = 0; ar_done = 0; end

      awready = ($urandom_range(99) < 32'(aw_pct));
      wready  = ($urandom_range(99) < 32'(w_pct));
      arready = ($urandom_range(99) < 32'(ar_pct));
      if (aw_done && w_done && !bvalid && $urandom_range(99) < 32'(b_pct)) begin
         logic e;
         e = ($urandom_range(99) < 32'(err_pct));
         bvalid = 1; bresp = e ? bresp_err : 2'b00;
         slave_mem[s_awaddr] = s_wdata;
         err_q.push_back(e);
      end
      if (ar_done && !rvalid && $urandom_range(99) < 32'(r_pct)) begin
         logic e;
         e = ($urandom_range(99) < 32'(err_pct));
         rvalid = 1; rresp = e ? rresp_err : 2'b00;
         rdata = slave_mem[s_araddr];
         err_q.push_back(e);
      end

      if (stim_q.size() != 0 && $urandom_range(99) < 32'(req_pct)) begin
         req_valid = 1; req_write = stim_q[0].wr; req_addr = stim_q[0].addr; req_wdata = stim_q[0].data;
      end else begin
         req_valid = 0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
      end

      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (aw_hs) begin
         check_val("aw_expected", 32'(exp_q.size() != 0 && !aw_done), 1);
         if (exp_q.size() != 0) begin
            check_val("aw_is_write", 32'(exp_q[0].wr), 1);
            check_val("awaddr", 32'(awaddr), 32'(exp_q[0].addr));
         end
         s_awaddr = awaddr;
      end
      if (w_hs) begin
         check_val("w_expected", 32'(exp_q.size() != 0 && !w_done), 1);
         if (exp_q.size() != 0) check_val("wdata", 32'(wdata), 32'(exp_q[0].data));
         s_wdata = wdata;
      end
      if (ar_hs) begin
         check_val("ar_expected", 32'(exp_q.size() != 0 && !ar_done), 1);
         if (exp_q.size() != 0) begin
            check_val("ar_is_read", 32'(exp_q[0].wr), 0);
            check_val("araddr", 32'(araddr), 32'(exp_q[0].addr));
         end
         s_araddr = araddr;
      end
      if (req_valid && req_ready) begin
         req_t r;
         r = stim_q.pop_front();
         r.acc_cyc = cyc;
         exp_q.push_back(r);
      end
      prev_awv = awvalid; prev_awaddr = awaddr;
      prev_wv  = wvalid;  prev_wdata  = wdata;
      prev_arv = arvalid; prev_araddr = araddr;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check_val("drain_left", 32'(stim_q.size() + exp_q.size()), 0);
      repeat (3) step();
   endtask

   task automatic restart();
      rst_n = 1'b0;
      flush_tb();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_err_count"}, 32'(err_count), 32'(exp_errs));
      check_val({tag, "_fifo_count"}, 32'(fifo_count), 0);
      check_val({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int n, base;
      set_pct(100);
      err_pct = 0;
      flush_tb();
      repeat (2) @(negedge clk);
      check_val("rst_awvalid", 32'(awvalid), 0);
      check_val("rst_wvalid", 32'(wvalid), 0);
      check_val("rst_arvalid", 32'(arvalid), 0);
      check_val("rst_bready", 32'(bready), 0);
      check_val("rst_rready", 32'(rready), 0);
      check_val("rst_rsp_valid", 32'(rsp_valid), 0);
      check_val("rst_rsp_data", 32'(rsp_data), 0);
      check_val("rst_rsp_err", 32'(rsp_err), 0);
      check_val("rst_fifo_count", 32'(fifo_count), 0);
      check_val("rst_err_count", 32'(err_count), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_req_ready", 32'(req_ready), 1);
      rst_n = 1'b1;
      step();
      check_val("post_rst_req_ready", 32'(req_ready), 1);

      // write then read back through a zero-wait slave
      add_req(1'b1, 2'd2, 8'h04);
      add_req(1'b0, 2'd2, 8'hA5);
      drain(100);
      check_val("wr_latency", 32'(wr_lat), 4);
      check_val("wr_rd_rsp_count", 32'(rsp_seen), 2);
      check_quiet("wr_rd");

      // fill: AXI side stalled, one request sits in the FSM and DEPTH in the FIFO
      aw_pct = 0; w_pct = 0; ar_pct = 0;
      for (int i = 0; i < DEPTH + 2; i++) add_req(1'($urandom), AW'($urandom), DW'($urandom));
      repeat (10) step();
      check_val("fill_accepted", 32'(exp_q.size()), 32'(DEPTH + 1));
      check_val("fill_held_off", 32'(stim_q.size()), 1);
      check_val("fill_fifo_count", 32'(fifo_count), 32'(DEPTH));
      check_val("fill_req_ready", 32'(req_ready), 0);
      check_val("fill_busy", 32'(busy), 1);
      set_pct(100);
      base = rsp_seen;
      drain(200);
      check_val("fill_rsp_count", 32'(rsp_seen - base), 32'(DEPTH + 2));
      check_quiet("fill");

      // split AW/W: address accepted, data held off for a few cycles
      aw_pct = 100; w_pct = 0;
      base = rsp_seen;
      add_req(1'b1, 2'd1, 8'h3C);
      n = 0;
      while (!aw_done && n < 20) begin step(); n++; end
      check_val("split_aw_done", 32'(aw_done), 1);
      for (int i = 0; i < 3; i++) begin
         check_val("split_awvalid_low", 32'(awvalid), 0);
         check_val("split_wvalid_high", 32'(wvalid), 1);
         step();
      end
      w_pct = 100;
      drain(50);
      check_val("split_rsp_count", 32'(rsp_seen - base), 1);

      // error responses and saturation
      restart();
      set_pct(100);
      err_pct = 100;
      add_req(1'b1, 2'd1, 8'h5A);
      add_req(1'b0, 2'd1, 8'h00);
      drain(100);
      check_val("err_count_two", 32'(err_count), 2);
      for (int i = 0; i < 256; i++) add_req(1'($urandom), AW'($urandom), DW'($urandom));
      drain(4000);
      check_val("err_count_sat", 32'(err_count), 255);
      check_quiet("err_sat");

      // reset while waiting for read data with two requests queued
      restart();
      set_pct(100);
      err_pct = 0;
      r_pct = 0;
      add_req(1'b0, 2'd3, 8'h00);
      add_req(1'b1, 2'd0, 8'h11);
      add_req(1'b1, 2'd1, 8'h22);
      n = 0;
      while (!(rready && fifo_count == 2) && n < 20) begin step(); n++; end
      check_val("mid_in_rd_r", 32'(rready && fifo_count == 2), 1);
      rst_n = 1'b0;
      flush_tb();
      @(negedge clk);
      check_val("mid_arvalid", 32'(arvalid), 0);
      check_val("mid_rready", 32'(rready), 0);
      check_val("mid_fifo_count", 32'(fifo_count), 0);
      check_val("mid_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_pct(100);
      base = rsp_seen;
      repeat (10) step();
      check_val("mid_no_rsp", 32'(rsp_seen - base), 0);
      check_quiet("mid");

      // randomized traffic with random backpressure and errors
      for (int k = 0; k < 5; k++) begin
         aw_pct  = int'($urandom_range(100, 30));
         w_pct   = int'($urandom_range(100, 30));
         ar_pct  = int'($urandom_range(100, 30));
         b_pct   = int'($urandom_range(100, 30));
         r_pct   = int'($urandom_range(100, 30));
         req_pct = int'($urandom_range(100, 20));
         err_pct = int'($urandom_range(30, 0));
         for (int i = 0; i < 60; i++) add_req(1'($urandom), AW'($urandom), DW'($urandom));
         drain(4000);
         check_quiet("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
